// File: rtl/acq_sched_pkg.sv
// Shared types and constants for the acquisition scheduler.
// The 110.592 MHz tick constant gives 10 ms per tick.
package acq_pkg;

   localparam int TICK_CYCLES_110M = 1105920;
   localparam int STAMP_W          = 28;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_PERIOD = 2'd1,
      ISSUE       = 2'd2,
      WAIT_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/acq_sched_rr_pick.sv
// Combinational round-robin selector: first set bit of mask after last, wrapping.
// any is low when no channel is enabled; idx is then 0 and must be ignored.
module rr_pick #(
   parameter int NUM_CH = 4,
   localparam int CH_W  = $clog2(NUM_CH),
   localparam int CW1   = CH_W + 1
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   last,
   output logic [CH_W-1:0]   idx,
   output logic              any
);

   logic [CW1-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      idx  = '0;
      any  = |mask;
      cand = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         cand = {1'b0, last} + CW1'(k);
         if (cand >= CW1'(NUM_CH)) cand = cand - CW1'(NUM_CH);
         if (mask[cand[CH_W-1:0]]) idx = cand[CH_W-1:0];
      end
   end

endmodule

// File: rtl/acq_sched.sv
// Acquisition scheduler: derives a tick from clk, grants one slot per period to the
// next enabled channel round-robin, timestamps each start, flags timeouts and overruns.
module acq_sched
   import acq_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int TICK_CYCLES   = TICK_CYCLES_110M,
   parameter int TIMEOUT_TICKS = 8,
   localparam int CH_W         = $clog2(NUM_CH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [7:0]         period_ticks,
   input  logic [NUM_CH-1:0]  ch_mask,
   input  logic [NUM_CH-1:0]  acq_done,
   output logic [NUM_CH-1:0]  acq_start,
   output logic [CH_W-1:0]    ch_sel,
   output logic               busy,
   output logic [STAMP_W-1:0] stamp,
   output logic               stamp_valid,
   output logic               timeout_err,
   output logic               overrun_err,
   output state_t             dbg_state
);

   localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

   // Handshake: acq_start[ch] is a one-cycle pulse opening a grant; the grant closes on
   // the first cycle acq_done[ch_sel] is sampled high while busy, or on timeout.
   // acq_done on any other channel, or outside busy, has no effect.

   state_t               state, state_nxt;
   logic [PRE_W-1:0]     prescaler;
   logic [7:0]           per_cnt;
   logic [TO_W-1:0]      to_cnt;
   logic [STAMP_W-1:0]   cyc_cnt;
   logic                 pending;
   logic [CH_W-1:0]      last;

   logic                 tick, expire, done_hit, to_hit;
   logic [7:0]           eff_period;
   logic [CH_W-1:0]      pick_idx;
   logic                 pick_any;

   logic                 grant;
   logic [NUM_CH-1:0]    start_nxt;
   logic                 sv_nxt, to_nxt, ov_nxt;

   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .mask (ch_mask),
      .last (last),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign tick       = (prescaler == PRE_W'(TICK_CYCLES - 1));
   assign eff_period = (period_ticks == 8'd0) ? 8'd1 : period_ticks;
   // >= rather than == so a period lowered mid-count expires on the next tick.
   assign expire     = tick && ((int'(per_cnt) + 1) >= int'(eff_period));
   assign done_hit   = acq_done[ch_sel];
   assign to_hit     = tick && ((int'(to_cnt) + 1) >= TIMEOUT_TICKS);

   assign busy      = (state == WAIT_DONE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!run) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:        state_nxt = WAIT_PERIOD;
            WAIT_PERIOD: if (pending || expire) state_nxt = ISSUE;
            ISSUE:       state_nxt = pick_any ? WAIT_DONE : WAIT_PERIOD;
            WAIT_DONE:   if (done_hit || to_hit) state_nxt = WAIT_PERIOD;
            default:     state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      grant     = 1'b0;
      start_nxt = '0;
      sv_nxt    = 1'b0;
      to_nxt    = 1'b0;
      ov_nxt    = 1'b0;
      if (run) begin
         case (state)
            ISSUE: begin
               if (pick_any) begin
                  grant     = 1'b1;
                  start_nxt = NUM_CH'(1) << pick_idx;
               end
            end
            WAIT_DONE: begin
               ov_nxt = expire;
               sv_nxt = done_hit;
               to_nxt = to_hit && !done_hit;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acq_start   <= '0;
         ch_sel      <= '0;
         stamp       <= '0;
         stamp_valid <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
         prescaler   <= '0;
         per_cnt     <= '0;
         to_cnt      <= '0;
         cyc_cnt     <= '0;
         pending     <= 1'b0;
         last        <= CH_W'(NUM_CH - 1);
      end else begin
         acq_start   <= start_nxt;
         stamp_valid <= sv_nxt;
         timeout_err <= to_nxt;
         overrun_err <= ov_nxt;
         if (grant) begin
            ch_sel <= pick_idx;
            last   <= pick_idx;
            stamp  <= cyc_cnt;
         end
         if (!run || state == IDLE) begin
            prescaler <= '0;
            per_cnt   <= '0;
            to_cnt    <= '0;
            cyc_cnt   <= '0;
            pending   <= 1'b0;
            last      <= CH_W'(NUM_CH - 1);
         end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            cyc_cnt   <= cyc_cnt + STAMP_W'(1);
            if (tick) per_cnt <= expire ? 8'd0 : per_cnt + 8'd1;
            if (state == ISSUE) begin
               // A grant consumes any held expiry; one landing in this cycle is kept.
               pending <= expire;
               to_cnt  <= '0;
            end else if (state == WAIT_DONE) begin
               if (expire) pending <= 1'b1;
               if (tick)   to_cnt  <= to_cnt + TO_W'(1);
            end
         end
      end
   end

endmodule
